// File: rtl/lcd_driver_pkg.sv
// lcd_driver_pkg: FSM states, command-word field positions, init ROM.
// Init ROM exists only when LCD_DRIVER_INIT_EN is defined.
package lcd_driver_pkg;

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_CMD,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  localparam int RS_BIT = 17;
  localparam int RW_BIT = 16;
  localparam int DB_HI  = 15;
  localparam int DB_LO  = 8;
  localparam int WT_HI  = 7;
  localparam int WT_LO  = 0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

`ifdef LCD_DRIVER_INIT_EN
  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] v;
    case (idx)
      2'd0:    v = 8'h38;
      2'd1:    v = 8'h0C;
      2'd2:    v = 8'h01;
      default: v = 8'h06;
    endcase
    return v;
  endfunction
`endif

endpackage

// File: rtl/lcd_driver_timer.sv
// lcd_driver_timer: loadable down-counter; o_done while count <= 1,
// so a state loaded with L lasts exactly L cycles.
module lcd_driver_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt <= W'(1));

endmodule

// File: rtl/lcd_driver.sv
// lcd_driver: HD44780 8-bit bus cycle generator with post-cycle wait.
// Define LCD_DRIVER_INIT_EN to compile in the power-up init sequence.
module lcd_driver
  import lcd_driver_pkg::*;
#(
  parameter int T_SETUP       = 2,
  parameter int T_PULSE       = 12,
  parameter int T_HOLD        = 2,
  parameter int WAIT_UNIT     = 50,
  parameter int INIT_WAIT     = 750000,
  parameter int INIT_CMD_WAIT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [17:0] dataIn,
  output logic [7:0]  dataOut,
  output logic        RS,
  output logic        RW,
  output logic        enableOut
);

  localparam int WW = 16 + $clog2(WAIT_UNIT);
  localparam int C0 = imax(WW, $clog2(INIT_WAIT + 1));
  localparam int C1 = imax(C0, $clog2(INIT_CMD_WAIT + 1));
  localparam int C2 = imax(C1, $clog2(T_PULSE + 1));
  localparam int CW = imax(C2, imax($clog2(T_SETUP + 1),
                                    $clog2(T_HOLD + 1)));

  state_t        r_state;
  logic [7:0]    r_wait;
  logic          w_load;
  logic [CW-1:0] w_val;
  logic [CW-1:0] w_wait;
  logic          w_done;

`ifdef LCD_DRIVER_INIT_EN
  logic       r_init;
  logic       r_armed;
  logic [1:0] r_idx;
`endif

  assign w_wait = CW'(r_wait) * CW'(WAIT_UNIT);

  lcd_driver_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_val),
    .o_done (w_done)
  );

  // Timer is reloaded on the same edge that enters the next timed state.
  always_comb begin
    w_load = 1'b0;
    w_val  = '0;
    case (r_state)
      S_IDLE:  begin w_load = enable; w_val = CW'(T_SETUP); end
      S_SETUP: begin w_load = w_done; w_val = CW'(T_PULSE); end
      S_PULSE: begin w_load = w_done; w_val = CW'(T_HOLD);  end
      S_HOLD: begin
        w_load = w_done;
        w_val  = w_wait;
`ifdef LCD_DRIVER_INIT_EN
        if (r_init) w_val = CW'(INIT_CMD_WAIT);
`endif
      end
`ifdef LCD_DRIVER_INIT_EN
      S_INIT_WAIT: begin
        w_load = !r_armed || w_done;
        w_val  = r_armed ? CW'(T_SETUP) : CW'(INIT_WAIT - 1);
      end
      S_INIT_CMD: begin w_load = w_done; w_val = CW'(T_SETUP); end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef LCD_DRIVER_INIT_EN
      r_state <= S_INIT_WAIT;
      r_init  <= 1'b1;
      r_armed <= 1'b0;
      r_idx   <= 2'd0;
`else
      r_state <= S_IDLE;
`endif
      dataOut   <= 8'h00;
      RS        <= 1'b0;
      RW        <= 1'b0;
      enableOut <= 1'b0;
      r_wait    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: if (enable) begin
          dataOut <= dataIn[DB_HI:DB_LO];
          RS      <= dataIn[RS_BIT];
          RW      <= dataIn[RW_BIT];
          r_wait  <= dataIn[WT_HI:WT_LO];
          r_state <= S_SETUP;
        end
        S_SETUP: if (w_done) begin
          enableOut <= 1'b1;
          r_state   <= S_PULSE;
        end
        S_PULSE: if (w_done) begin
          enableOut <= 1'b0;
          r_state   <= S_HOLD;
        end
        S_HOLD: if (w_done) begin
`ifdef LCD_DRIVER_INIT_EN
          if (r_init) r_state <= S_INIT_CMD;
          else
`endif
          if (r_wait == 8'd0) r_state <= S_IDLE;
          else r_state <= S_WAIT;
        end
        S_WAIT: if (w_done) r_state <= S_IDLE;
`ifdef LCD_DRIVER_INIT_EN
        S_INIT_WAIT: begin
          r_armed <= 1'b1;
          if (r_armed && w_done) begin
            dataOut <= init_rom(2'd0);
            RS      <= 1'b0;
            RW      <= 1'b0;
            r_idx   <= 2'd0;
            r_state <= S_SETUP;
          end
        end
        S_INIT_CMD: if (w_done) begin
          if (r_idx == 2'(INIT_LEN - 1)) begin
            r_init  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            dataOut <= init_rom(r_idx + 2'd1);
            r_state <= S_SETUP;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: random + directed stimulus against a cycle-arithmetic
// reference of the LCD bus timing.
module tb_lcd_driver;

  localparam int TS  = 2;
  localparam int TP  = 4;
  localparam int TH  = 2;
  localparam int WU  = 3;
  localparam int IW  = 10;
  localparam int ICW = 5;
`ifdef LCD_DRIVER_INIT_EN
  localparam int INIT_CYC = IW + 4 * (TS + TP + TH + ICW) + 2;
`else
  localparam int INIT_CYC = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [17:0] dataIn = '0;
  logic [7:0]  dataOut;
  logic        RS, RW, enableOut;

  int errors = 0;
  int checks = 0;

  lcd_driver #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .WAIT_UNIT(WU), .INIT_WAIT(IW), .INIT_CMD_WAIT(ICW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .dataIn(dataIn),
    .dataOut(dataOut), .RS(RS), .RW(RW), .enableOut(enableOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: each command occupies edges [k, k+TS+TP+TH+wait];
  // E is high after edges k+TS .. k+TS+TP-1.
  int         cyc = 0;
  int         m_k = -1000;
  int         m_end = -1;
  logic [7:0] m_db = 8'h00;
  logic       m_rs = 1'b0;
  logic       m_rw = 1'b0;
  int         m_idx = 0;
  int         m_next = IW;

  function automatic logic [7:0] rom(input int i);
    case (i)
      0: return 8'h38;
      1: return 8'h0C;
      2: return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; m_k = -1000; m_end = -1;
      m_db = 8'h00; m_rs = 1'b0; m_rw = 1'b0;
      m_idx = 0; m_next = IW;
    end else begin
      bit host_ok;
      cyc++;
      host_ok = 1'b1;
`ifdef LCD_DRIVER_INIT_EN
      host_ok = (m_idx == 4);
      if (m_idx < 4 && cyc == m_next) begin
        m_k = cyc; m_db = rom(m_idx); m_rs = 1'b0; m_rw = 1'b0;
        m_end = cyc + TS + TP + TH + ICW;
        m_next = m_end;
        m_idx++;
      end else
`endif
      if (host_ok && cyc > m_end && enable) begin
        m_k = cyc;
        m_db = dataIn[15:8];
        m_rs = dataIn[17];
        m_rw = dataIn[16];
        m_end = cyc + TS + TP + TH + int'(dataIn[7:0]) * WU;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_E", enableOut, 0);
      chk("rst_DB", dataOut, 0);
      chk("rst_RS", RS, 0);
      chk("rst_RW", RW, 0);
    end else begin
      chk("E", enableOut, (cyc >= m_k + TS) && (cyc < m_k + TS + TP));
      chk("DB", dataOut, m_db);
      chk("RS", RS, m_rs);
      chk("RW", RW, m_rw);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, t;
    logic sawE;
    logic [31:0] r;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_rst_DB", dataOut, 8'h00);
    chk("hold_rst_E", enableOut, 0);
    #1 rst = 1'b1;
`ifdef LCD_DRIVER_INIT_EN
    sawE = 1'b0;
    repeat (IW + TS - 1) begin
      @(negedge clk);
      sawE = sawE | enableOut;
    end
    chk("init_quiet", sawE, 0);
    @(negedge clk);
    chk("init_E0", enableOut, 1);
    chk("init_DB0", dataOut, 8'h38);
    repeat (INIT_CYC - IW - TS) @(negedge clk);
`else
    repeat (INIT_CYC) @(negedge clk);
    chk("idle_DB", dataOut, 8'h00);
    chk("idle_E", enableOut, 0);
`endif

    // single write, wait field 171
    @(negedge clk); #1;
    dataIn = 18'b10_10101010_10101011;
    enable = 1'b1;
    @(negedge clk);
    k = cyc;
    chk("sw_DB", dataOut, 8'hAA);
    chk("sw_RS", RS, 1);
    chk("sw_RW", RW, 0);
    #1 enable = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("sw_Ewin", enableOut, (j >= 2 && j <= 5));
      if (j == 3) #1 dataIn = {2'b01, 8'h5C, 8'd0};
      if (j == 4) chk("sw_hold_DB", dataOut, 8'hAA);
      if (j == 8) #1 enable = 1'b1;
    end
    t = 0;
    while (dataOut !== 8'h5C && t < 700) begin
      @(negedge clk);
      t++;
    end
    chk("sw_return", cyc - k, 522);
    chk("sw_RW1", RW, 1);
    k2 = cyc;
    #1 dataIn = {2'b00, 8'h01, 8'd0};
    t = 0;
    while (dataOut !== 8'h01 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("n0_return", cyc - k2, 9);
    #1 enable = 1'b0;
    repeat (12) @(negedge clk);

    // reset during PULSE
    #1 dataIn = {2'b10, 8'h77, 8'd2};
    enable = 1'b1;
    t = 0;
    while (enableOut !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rp_pulse", enableOut, 1);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rp_async_E", enableOut, 0);
    chk("rp_async_DB", dataOut, 8'h00);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (INIT_CYC) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      r = $urandom;
      dataIn = {r[17:8], 8'($urandom_range(0, 3))};
      enable = ($urandom_range(0, 2) == 0);
    end
    #1 enable = 1'b0;
    repeat (30) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
